lab2_proc_fetch_unit: RTL

- Parametrised, decoupled instruction-fetch front end for the next-generation pipelined processor.
- Replaces the single-outstanding fetch PC register and drop logic with a self-contained unit that has:
  - a configurable number of outstanding imem requests;
  - credit-based response buffering;
  - squash-on-redirect with drop counting.
- Sits between the instruction memory port and the decode stage; presents {pc, inst} to D over a val/rdy interface.

---
 rtl/lab2_proc_fetch_pkg.sv | 22 ++
 rtl/lab2_proc_FetchQueueVRTL.sv | 76 +++++++
 rtl/lab2_proc_fetch_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lab2_proc_fetch_pkg.sv
// Shared definitions for the fetch front end.
//   c_reset_vector   default first fetch PC after reset
//   fetch_entry_t    {pc, inst} record at the default address/instruction widths
//   cnt_nbits()      width of a counter that must hold 0..n inclusive
package lab2_proc_fetch_pkg;

  localparam logic [31:0] c_reset_vector = 32'h0000_0200;
  localparam int          c_addr_nbits   = 32;
  localparam int          c_inst_nbits   = 32;

  // A package typedef cannot take module parameters, so this is the record
  // at default widths; the top packs {pc, inst} itself for other widths.
  typedef struct packed {
    logic [c_addr_nbits-1:0] pc;
    logic [c_inst_nbits-1:0] inst;
  } fetch_entry_t;

  function automatic int cnt_nbits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lab2_proc_FetchQueueVRTL.sv
// Synchronous FIFO with flush, used for the fetch PC FIFO and output queue.
//   clk, reset       clock, async active-low reset
//   flush_i          empties the FIFO; overrides any enq/deq this cycle
//   enq_val_i/data_i push (ignored when full)
//   deq_rdy_i        pop head (ignored when empty)
//   deq_val_o/data_o head entry, valid when non-empty
//   count_o          occupancy
module lab2_proc_FetchQueueVRTL
  import lab2_proc_fetch_pkg::*;
#(
  parameter int p_nbits = 32,
  parameter int p_depth = 2
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          enq_val_i,
  input  logic [p_nbits-1:0]            enq_data_i,
  input  logic                          deq_rdy_i,
  output logic                          deq_val_o,
  output logic [p_nbits-1:0]            deq_data_o,
  output logic [cnt_nbits(p_depth)-1:0] count_o
);

  localparam int c_cw = cnt_nbits(p_depth);
  localparam int c_pw = (p_depth > 1) ? $clog2(p_depth) : 1;

  logic [p_nbits-1:0] buf_q [p_depth];
  logic [c_pw-1:0]    head_q, head_d, tail_q, tail_d;
  logic [c_cw-1:0]    cnt_q, cnt_d;
  logic               enq_fire, deq_fire;

  function automatic logic [c_pw-1:0] bump(input logic [c_pw-1:0] p);
    return (p == c_pw'(p_depth - 1)) ? '0 : p + c_pw'(1);
  endfunction

  assign enq_fire = enq_val_i && !flush_i && (cnt_q != c_cw'(p_depth));
  assign deq_fire = deq_rdy_i && !flush_i && (cnt_q != '0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (deq_fire) head_d = bump(head_q);
      if (enq_fire) tail_d = bump(tail_q);
      cnt_d = cnt_q + c_cw'(enq_fire) - c_cw'(deq_fire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (enq_fire) buf_q[tail_q] <= enq_data_i;
  end

  assign deq_val_o  = (cnt_q != '0);
  assign deq_data_o = buf_q[head_q];
  assign count_o    = cnt_q;

endmodule

// File: rtl/lab2_proc_fetch_unit.sv
// Decoupled instruction-fetch front end.
//   imemreq_*   fetch request to instruction memory (addr = next PC)
//   imemresp_*  in-order instruction responses; rdy is 1 outside reset
//   redirect_*  squash everything in flight and refetch from target
//   fetch_*     {pc, inst} head of the output queue toward decode
//   inflight    outstanding request count
// Issue is credit-limited by inflight + output-queue occupancy, so a response
// always has a queue slot and imemresp_rdy never needs to drop.
module lab2_proc_fetch_unit
  import lab2_proc_fetch_pkg::*;
#(
  parameter int                      p_addr_nbits   = 32,
  parameter int                      p_inst_nbits   = 32,
  parameter int                      p_max_inflight = 2,
  parameter int                      p_queue_depth  = 2,
  parameter logic [p_addr_nbits-1:0] p_reset_vector = p_addr_nbits'(c_reset_vector)
)(
  input  logic                                 clk,
  input  logic                                 reset,
  output logic                                 imemreq_val,
  input  logic                                 imemreq_rdy,
  output logic [p_addr_nbits-1:0]              imemreq_addr,
  input  logic                                 imemresp_val,
  output logic                                 imemresp_rdy,
  input  logic [p_inst_nbits-1:0]              imemresp_data,
  input  logic                                 redirect_val,
  input  logic [p_addr_nbits-1:0]              redirect_target,
  output logic                                 fetch_val,
  input  logic                                 fetch_rdy,
  output logic [p_addr_nbits-1:0]              fetch_pc,
  output logic [p_inst_nbits-1:0]              fetch_inst,
  output logic [$clog2(p_max_inflight+1)-1:0]  inflight
);

  localparam int c_iw = cnt_nbits(p_max_inflight);
  localparam int c_qw = cnt_nbits(p_queue_depth);
  localparam int c_ew = p_addr_nbits + p_inst_nbits;

  logic [p_addr_nbits-1:0] pc_q, pc_d;
  logic [c_iw-1:0]         inflight_q, inflight_d;
  logic [c_iw-1:0]         drop_q, drop_d;

  logic                    req_fire, resp_fire, resp_keep, can_issue;
  logic                    pcq_val;
  logic [p_addr_nbits-1:0] pcq_pc;
  logic [c_iw-1:0]         pcq_cnt;
  logic [c_ew-1:0]         outq_head;
  logic [c_qw-1:0]         outq_cnt;

  assign can_issue = (int'(inflight_q) < p_max_inflight) &&
                     ((int'(inflight_q) + int'(outq_cnt)) < p_queue_depth);

  // Gated by the reset pin so nothing handshakes while held in reset.
  assign imemreq_val  = reset && !redirect_val && can_issue;
  assign imemreq_addr = pc_q;
  assign imemresp_rdy = reset;

  assign req_fire  = imemreq_val && imemreq_rdy;
  assign resp_fire = imemresp_val && imemresp_rdy;
  // Responses owed to pre-redirect requests are discarded while drop_q > 0;
  // a response landing in a redirect cycle is squashed too.
  assign resp_keep = resp_fire && (drop_q == '0) && !redirect_val && pcq_val;

  always_comb begin
    inflight_d = inflight_q + c_iw'(req_fire) - c_iw'(resp_fire);
    drop_d     = drop_q;
    pc_d       = pc_q;
    if (redirect_val) begin
      // Every request still outstanding after this cycle becomes a drop.
      drop_d = inflight_q - c_iw'(resp_fire);
      pc_d   = redirect_target;
    end else begin
      if (resp_fire && (drop_q != '0)) drop_d = drop_q - c_iw'(1);
      if (req_fire) pc_d = pc_q + p_addr_nbits'(4);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= p_reset_vector;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  lab2_proc_FetchQueueVRTL #(.p_nbits(p_addr_nbits), .p_depth(p_max_inflight)) u_pcq (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (redirect_val),
    .enq_val_i  (req_fire),
    .enq_data_i (pc_q),
    .deq_rdy_i  (resp_keep),
    .deq_val_o  (pcq_val),
    .deq_data_o (pcq_pc),
    .count_o    (pcq_cnt)
  );

  lab2_proc_FetchQueueVRTL #(.p_nbits(c_ew), .p_depth(p_queue_depth)) u_outq (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (redirect_val),
    .enq_val_i  (resp_keep),
    .enq_data_i ({pcq_pc, imemresp_data}),
    .deq_rdy_i  (fetch_rdy),
    .deq_val_o  (fetch_val),
    .deq_data_o (outq_head),
    .count_o    (outq_cnt)
  );

  assign fetch_pc   = outq_head[c_ew-1:p_inst_nbits];
  assign fetch_inst = outq_head[p_inst_nbits-1:0];
  assign inflight   = inflight_q;

  // Protocol checks: no orphan responses, and every outstanding request is
  // either tracked by a PC FIFO entry or counted as a drop.
  always @(posedge clk) begin
    if (reset) begin
      assert (!(imemresp_val && (inflight_q == '0)));
      assert ((int'(pcq_cnt) + int'(drop_q)) == int'(inflight_q));
    end
  end

endmodule
